mem_responder: RTL and testbench

//  Memory-side responder for the processor's two memory request ports: instruction fetch
//  (read-only) and data (load/store). Replaces the zero-wait dual-port memory with a

---
 rtl/mem_resp_pkg.sv | 25 ++
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared encodings and arbitration helper for mem_responder
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam int WAIT_MAX   = 7;
    localparam int WAIT_CNT_W = 3;

    // Round-robin between the two ports: on conflict, the port not served last wins.
    function automatic logic rr_pick(input logic fetch_req, input logic data_req,
                                     input logic last_grant);
        if (fetch_req && data_req) begin
            return ~last_grant;
        end
        return data_req ? PORT_DATA : PORT_FETCH;
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port RAM, synchronous write, combinational read, no reset
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fetch/data req-ack responder over a single-port RAM with wait states
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              busy
);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_wait_range_check
            $error("mem_responder: WAIT_CYCLES must be in 0..7");
        end
    endgenerate

    localparam bit                    ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic                  last_grant_q;
    logic                  gnt_port_q;
    logic [ADDR_W-1:0]     gnt_addr_q;
    logic                  gnt_we_q;
    logic [DATA_W-1:0]     gnt_wdata_q;

    logic              idle;
    logic              any_req;
    logic              arb_port;
    logic              eff_port;
    logic [ADDR_W-1:0] eff_addr;
    logic              eff_we;
    logic [DATA_W-1:0] eff_wdata;
    logic              enter_resp;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign idle     = (state_q == ST_IDLE);
    assign any_req  = if_req | d_req;
    assign arb_port = rr_pick(if_req, d_req, last_grant_q);
    assign busy     = ~idle;

    // With zero wait states the grant and the RAM access share one edge, so
    // the access must come from the live request instead of the grant registers.
    assign eff_port  = idle ? arb_port : gnt_port_q;
    assign eff_addr  = idle ? ((arb_port == PORT_DATA) ? d_addr : if_addr) : gnt_addr_q;
    assign eff_we    = idle ? ((arb_port == PORT_DATA) && d_we) : gnt_we_q;
    assign eff_wdata = idle ? d_wdata : gnt_wdata_q;

    assign mem_we = enter_resp && (eff_port == PORT_DATA) && eff_we;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .addr  (eff_addr),
        .wdata (eff_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    if (ZERO_WAIT) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wait_d  = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    wait_d     = '0;
                    enter_resp = 1'b1;
                end else begin
                    wait_d = wait_q - WAIT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= PORT_FETCH;
            gnt_port_q   <= PORT_FETCH;
            gnt_addr_q   <= '0;
            gnt_we_q     <= 1'b0;
            gnt_wdata_q  <= '0;
        end else if (idle && any_req) begin
            last_grant_q <= arb_port;
            gnt_port_q   <= arb_port;
            gnt_addr_q   <= eff_addr;
            gnt_we_q     <= eff_we;
            gnt_wdata_q  <= eff_wdata;
        end
    end

    // Read data is captured only on a port's own response, so it holds until that port's next ack.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_ack <= enter_resp && (eff_port == PORT_FETCH);
            d_ack  <= enter_resp && (eff_port == PORT_DATA);
            if (enter_resp && (eff_port == PORT_FETCH)) begin
                if_rdata <= mem_rdata;
            end
            if (enter_resp && (eff_port == PORT_DATA)) begin
                d_rdata <= eff_we ? eff_wdata : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench: transaction model plus directed vectors
module tb_mem_responder;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]      if_req = '0, d_req = '0, d_we = '0;
    logic [1:0][7:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [1:0]      if_ack, d_ack, busy;
    logic [1:0][7:0] if_rdata, d_rdata;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) dut_w2 (
        .clock(clock), .reset(rst_n),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_ack(d_ack[0]), .d_rdata(d_rdata[0]), .busy(busy[0])
    );

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut_w0 (
        .clock(clock), .reset(rst_n),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_ack(d_ack[1]), .d_rdata(d_rdata[1]), .busy(busy[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: grant at edge k, response data visible after edge k+W,
    // next grant possible at edge k+W+2.
    int          cyc = 0;
    int          g_k[2], g_free[2];
    logic        g_last[2], g_port[2], g_we[2];
    logic [7:0]  g_addr[2], g_wd[2];
    logic [7:0]  mm[2][256];
    logic        e_if_ack[2], e_d_ack[2], e_busy[2];
    logic [7:0]  e_if_rd[2], e_d_rd[2];

    initial begin
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 256; a++) mm[i][a] = 'x;
    end

    task automatic model_step(input int i);
        int w;
        w = (i == 0) ? 2 : 0;
        e_if_ack[i] = 1'b0;
        e_d_ack[i]  = 1'b0;
        if (!rst_n) begin
            g_k[i] = -1000; g_free[i] = 0; g_last[i] = 1'b0;
            e_if_rd[i] = 8'h00; e_d_rd[i] = 8'h00; e_busy[i] = 1'b0;
            return;
        end
        if (cyc >= g_free[i] && (if_req[i] || d_req[i])) begin
            g_port[i] = (if_req[i] && d_req[i]) ? ~g_last[i] : d_req[i];
            g_last[i] = g_port[i];
            g_k[i]    = cyc;
            g_free[i] = cyc + w + 2;
            g_addr[i] = g_port[i] ? d_addr[i] : if_addr[i];
            g_we[i]   = g_port[i] & d_we[i];
            g_wd[i]   = d_wdata[i];
        end
        if (cyc == g_k[i] + w) begin
            if (!g_port[i]) begin
                e_if_ack[i] = 1'b1;
                e_if_rd[i]  = mm[i][g_addr[i]];
            end else begin
                e_d_ack[i] = 1'b1;
                if (g_we[i]) begin
                    mm[i][g_addr[i]] = g_wd[i];
                    e_d_rd[i] = g_wd[i];
                end else begin
                    e_d_rd[i] = mm[i][g_addr[i]];
                end
            end
        end
        e_busy[i] = (cyc >= g_k[i]) && (cyc <= g_k[i] + w);
    endtask

    always @(posedge clock) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    always @(posedge clock) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_if_ack[%0d]", i), 32'(if_ack[i]), 32'(e_if_ack[i]));
            chk($sformatf("model_d_ack[%0d]", i), 32'(d_ack[i]), 32'(e_d_ack[i]));
            chk($sformatf("model_busy[%0d]", i), 32'(busy[i]), 32'(e_busy[i]));
            if (!$isunknown(e_if_rd[i]))
                chk($sformatf("model_if_rdata[%0d]", i), 32'(if_rdata[i]), 32'(e_if_rd[i]));
            if (!$isunknown(e_d_rd[i]))
                chk($sformatf("model_d_rdata[%0d]", i), 32'(d_rdata[i]), 32'(e_d_rd[i]));
        end
    end

    task automatic xact(input int i, input bit port, input bit we, input logic [7:0] a,
                        input logic [7:0] wd, output logic [7:0] rd, output int lat,
                        output int nbusy);
        @(negedge clock);
        if (port) begin
            d_req[i] = 1'b1; d_we[i] = we; d_addr[i] = a; d_wdata[i] = wd;
        end else begin
            if_req[i] = 1'b1; if_addr[i] = a;
        end
        lat = 0; nbusy = 0; rd = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (busy[i]) nbusy++;
            if ((port ? d_ack[i] : if_ack[i]) === 1'b1) begin
                lat = n;
                rd  = port ? d_rdata[i] : if_rdata[i];
                break;
            end
        end
        if_req[i] = 1'b0; d_req[i] = 1'b0; d_we[i] = 1'b0;
        if (lat == 0) chk("xact_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        rst_n = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
    endtask

    logic [7:0] rd;
    int         lat, nb, nack;
    int         order[$], ack_at[$];
    logic [7:0] ack_dat[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        rst_n = 1'b1;

        // Reset in the middle of a store's wait states
        xact(0, 1, 1, 8'h10, 8'h11, rd, lat, nb);
        chk("t1_preload_latency", 32'(lat), 3);
        @(negedge clock);
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h10; d_wdata[0] = 8'h5A;
        @(negedge clock);
        chk("t1_busy_in_wait", 32'(busy[0]), 1);
        rst_n = 1'b0; d_req[0] = 1'b0; d_we[0] = 1'b0;
        #1;
        chk("t1_rst_if_ack", 32'(if_ack[0]), 0);
        chk("t1_rst_d_ack", 32'(d_ack[0]), 0);
        chk("t1_rst_busy", 32'(busy[0]), 0);
        chk("t1_rst_if_rdata", 32'(if_rdata[0]), 0);
        chk("t1_rst_d_rdata", 32'(d_rdata[0]), 0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        xact(0, 1, 0, 8'h10, 8'h00, rd, lat, nb);
        chk("t1_mem_unchanged", 32'(rd), 32'h11);

        // Fetch with two wait states
        xact(0, 1, 1, 8'h03, 8'hA7, rd, lat, nb);
        xact(0, 0, 0, 8'h03, 8'h00, rd, lat, nb);
        chk("t2_fetch_latency", 32'(lat), 3);
        chk("t2_fetch_data", 32'(rd), 32'hA7);
        chk("t2_busy_cycles", 32'(nb), 3);

        // Store then load
        xact(0, 1, 1, 8'h20, 8'h3C, rd, lat, nb);
        chk("t3_store_writethrough", 32'(rd), 32'h3C);
        xact(0, 1, 0, 8'h20, 8'h00, rd, lat, nb);
        chk("t3_load_data", 32'(rd), 32'h3C);

        // Conflict from reset: data first, then strict alternation
        pulse_reset();
        @(negedge clock);
        if_req[0] = 1'b1; if_addr[0] = 8'h03;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h20;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (if_ack[0] && d_ack[0]) chk("t4_both_acks", 1, 0);
            if (d_ack[0])  begin order.push_back(1); ack_at.push_back(n); ack_dat.push_back(d_rdata[0]); end
            if (if_ack[0]) begin order.push_back(0); ack_at.push_back(n); ack_dat.push_back(if_rdata[0]); end
            if (order.size() >= 4) break;
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        chk("t4_ack_count", 32'(order.size()), 4);
        for (int j = 0; j < 4 && j < order.size(); j++) begin
            chk($sformatf("t4_order_%0d", j), 32'(order[j]), (j % 2 == 0) ? 1 : 0);
            chk($sformatf("t4_cycle_%0d", j), 32'(ack_at[j]), 32'(3 + 4 * j));
            chk($sformatf("t4_data_%0d", j), 32'(ack_dat[j]), (j % 2 == 0) ? 32'h3C : 32'hA7);
        end

        // Zero wait states, continuous fetch stream
        xact(1, 1, 1, 8'h00, 8'h41, rd, lat, nb);
        chk("t5_store_latency", 32'(lat), 1);
        xact(1, 1, 1, 8'h01, 8'h42, rd, lat, nb);
        xact(1, 1, 1, 8'h02, 8'h43, rd, lat, nb);
        ack_at.delete(); ack_dat.delete();
        @(negedge clock);
        if_req[1] = 1'b1; if_addr[1] = 8'h00;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            if (if_ack[1]) begin
                ack_at.push_back(n); ack_dat.push_back(if_rdata[1]);
                if (ack_at.size() >= 3) break;
                if_addr[1] = if_addr[1] + 8'h01;
            end
        end
        if_req[1] = 1'b0;
        chk("t5_ack_count", 32'(ack_at.size()), 3);
        for (int j = 0; j < 3 && j < ack_at.size(); j++) begin
            chk($sformatf("t5_cycle_%0d", j), 32'(ack_at[j]), 32'(1 + 2 * j));
            chk($sformatf("t5_data_%0d", j), 32'(ack_dat[j]), 32'h41 + 32'(j));
        end

        // Requester drops d_req during wait; grant must stay latched
        @(negedge clock);
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'hFF; d_wdata[0] = 8'h81;
        @(negedge clock);
        d_req[0] = 1'b0; d_we[0] = 1'b0; d_addr[0] = 8'h00; d_wdata[0] = 8'h00;
        nack = 0;
        repeat (8) begin
            @(negedge clock);
            if (d_ack[0]) nack++;
        end
        chk("t6_single_ack", 32'(nack), 1);
        xact(0, 1, 0, 8'hFF, 8'h00, rd, lat, nb);
        chk("t6_mem_ff", 32'(rd), 32'h81);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
